lutram_readback_checker: RTL and testbench
==========================================

# lutram_readback_checker

Downstream checker for LUTRAM primitive tests. Consumes the read-back stream (SPO/DPO plus address) emitted by a LUTRAM test FSM during its READ phase and compares each sample against the written pattern. Reports pass/fail, mismatch count, first failing address and port, and address-sequence errors. Drives the board status LEDs in place of raw RAM outputs.

## Interface
Parameters:
- A_WIDTH, 5, address width; one full pass is 2**A_WIDTH samples.
- D_WIDTH, 1, data width per port.

Ports:
- clk_i  in  1  test clock (the divided test clock domain); one clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  pulse: clear results, arm for a new pass.
- valid_i  in  1  sample present this cycle.
- last_i  in  1  qualifies the final sample; ignored unless valid_i.
- addr_i  in  A_WIDTH  address of the sample.
- spo_i  in  D_WIDTH  single-port read data.
- dpo_i  in  D_WIDTH  dual-port read data.
- done_o  out  1  pass complete; results stable.
- pass_o  out  1  done_o and no errors.
- fail_o  out  1  done_o and any error.
- err_count_o  out  A_WIDTH+1  data mismatch samples, saturating.
- first_err_addr_o  out  A_WIDTH  address of first data mismatch.
- first_err_port_o  out  2  bit0 SPO, bit1 DPO mismatched at first error.
- seq_err_o  out  1  address order or sample count wrong.

## Operation
- Expected data for address a: {D_WIDTH{a[0]}} on both ports.
- States: IDLE, CHECK, DONE. Encoding 2'b00/01/10; 2'b11 returns to IDLE.
- IDLE: samples are ignored. start_i moves the FSM to CHECK and clears all results and the expected-address counter (exp_addr=0, sample count=0).
- CHECK: on each valid_i, the block does the following.
  - A sample mismatches when spo_i or dpo_i differs from expected. On a mismatch, err_count increments, saturating at all-ones.
  - On the first mismatch only, first_err_addr and first_err_port latch.
  - addr_i != exp_addr sets sticky seq_err. exp_addr increments and wraps at 2**A_WIDTH.
  - The sample counter counts accepted samples, width A_WIDTH+1, saturating.
  - valid_i with last_i moves the FSM to DONE. At that point, if the count including this sample != 2**A_WIDTH, seq_err is set.
- DONE: results hold. valid_i is ignored. start_i restarts (as from IDLE).
- start_i in CHECK restarts: results clear and the FSM stays in CHECK. start_i wins over a same-cycle valid_i, and that sample is discarded.
- More than 2**A_WIDTH samples before last_i: exp_addr wraps, and the count saturates or mismatches, so seq_err is set.
- pass_o = done & err_count==0 & !seq_err. fail_o = done & !pass_o.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Reset mid-CHECK aborts the pass immediately and returns all outputs to their reset values.
- Sample-to-result latency is 1 cycle. Counters, flags and first-error fields update on the edge that accepts the sample.
- done_o, pass_o and fail_o assert on the edge that accepts the last sample and are valid the cycle after.
- start_i clears outputs on the next edge, so done_o drops 1 cycle after start_i.
- No backpressure: every valid_i cycle in CHECK is consumed.
- Back-to-back valid_i every cycle is supported.

## Structure
- Shared package lutram_test_pkg holds:
  - the state localparams (also reused by the generator FSM);
  - an expected-data function exp_data(addr) returning {D_WIDTH{addr[0]}}.
- Sub-module sat_counter (parameter WIDTH; ports clr, inc, q) is used for both err_count and the sample count.
- All other logic stays inline.
- Estimated 150–250 lines of RTL.

## Test plan
- Clean pass: start_i, then 32 samples in order (addr 0..31, data=addr[0] on both ports, last_i on 31). Expected: pass_o=1, err_count_o=0, seq_err_o=0, done_o 1 cycle after the last sample.
- SPO flip at addr 7. Expected: fail_o=1, err_count_o=1, first_err_addr_o=7, first_err_port_o=2'b01.
- DPO flips at addr 3 and addr 20. Expected: err_count_o=2, first_err_addr_o=3, first_err_port_o=2'b10.
- Early last_i at addr 15. Expected: seq_err_o=1, fail_o=1, err_count_o=0.
- Address 9 skipped (10 sent in its place, 32 samples total). Expected: seq_err_o=1, fail_o=1.
- rst_i at sample 12 of a pass, then a new clean pass. Expected:
  - all outputs 0 the cycle after reset;
  - the new pass gives pass_o=1;
  - start_i during DONE clears done_o within 1 cycle.

Source files
------------

// File: rtl/lutram_test_pkg.sv
// Shared definitions for the LUTRAM test generator and read-back checker.
//   state_t  : test FSM state encoding (IDLE/CHECK/DONE)
//   exp_data : expected read data, every bit equals the address LSB
package lutram_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Widest data port the pattern function serves; callers truncate.
  localparam int unsigned EXP_DATA_MAX_W = 64;

  function automatic logic [EXP_DATA_MAX_W-1:0] exp_data(input logic addr_lsb);
    return {EXP_DATA_MAX_W{addr_lsb}};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : increment by one, holds at all-ones
//   q        : count
module sat_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lutram_readback_checker.sv
// Checks the LUTRAM read-back stream against the address-LSB pattern and
// reports pass/fail, mismatch count, first failing address/port and
// address-sequence errors.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   start_i          : clear results and arm a new pass
//   valid_i, last_i  : sample strobe, final-sample qualifier
//   addr_i           : sample address
//   spo_i, dpo_i     : single-/dual-port read data
//   done_o, pass_o, fail_o      : pass complete and verdict
//   err_count_o                 : saturating data-mismatch count
//   first_err_addr_o/port_o     : location of first data mismatch
//   seq_err_o                   : address order or sample count wrong
module lutram_readback_checker
  import lutram_test_pkg::*;
#(
  parameter int unsigned A_WIDTH = 5,
  parameter int unsigned D_WIDTH = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               valid_i,
  input  logic               last_i,
  input  logic [A_WIDTH-1:0] addr_i,
  input  logic [D_WIDTH-1:0] spo_i,
  input  logic [D_WIDTH-1:0] dpo_i,
  output logic               done_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic [A_WIDTH:0]   err_count_o,
  output logic [A_WIDTH-1:0] first_err_addr_o,
  output logic [1:0]         first_err_port_o,
  output logic               seq_err_o
);

  localparam int unsigned CNT_W = A_WIDTH + 1;
  // Sample count before the last sample of a complete pass.
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'((1 << A_WIDTH) - 1);

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   exp_addr_q, exp_addr_d;
  logic                 seq_err_d;
  logic [A_WIDTH-1:0]   first_err_addr_d;
  logic [1:0]           first_err_port_d;
  logic                 done_d, pass_d, fail_d;
  logic [CNT_W-1:0]     sample_count;
  logic [D_WIDTH-1:0]   exp_c;
  logic [1:0]           port_miss_c;
  logic                 accept_c, mismatch_c, clr_c, err_zero_c;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, sample acceptance and next result values.
  always_comb begin
    state_d          = state_q;
    accept_c         = 1'b0;
    clr_c            = start_i;
    exp_c            = D_WIDTH'(exp_data(addr_i[0]));
    port_miss_c      = {dpo_i != exp_c, spo_i != exp_c};
    exp_addr_d       = exp_addr_q;
    seq_err_d        = seq_err_o;
    first_err_addr_d = first_err_addr_o;
    first_err_port_d = first_err_port_o;

    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // start_i restarts the pass and discards a same-cycle sample
        if (!start_i && valid_i) begin
          accept_c = 1'b1;
          if (last_i) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_i) state_d = ST_CHECK;
      end
      default: state_d = ST_IDLE;
    endcase

    mismatch_c = accept_c && (port_miss_c != 2'b00);

    if (clr_c) begin
      exp_addr_d       = '0;
      seq_err_d        = 1'b0;
      first_err_addr_d = '0;
      first_err_port_d = 2'b00;
    end else if (accept_c) begin
      exp_addr_d = exp_addr_q + A_WIDTH'(1);
      if ((addr_i != exp_addr_q) || (last_i && (sample_count != FULL_M1))) begin
        seq_err_d = 1'b1;
      end
      // err_count is still zero only until the first mismatch is taken
      if (mismatch_c && (err_count_o == '0)) begin
        first_err_addr_d = addr_i;
        first_err_port_d = port_miss_c;
      end
    end

    err_zero_c = clr_c || ((err_count_o == '0) && !mismatch_c);
    done_d     = (state_d == ST_DONE);
    pass_d     = done_d && err_zero_c && !seq_err_d;
    fail_d     = done_d && !pass_d;
  end

  // Result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_addr_q       <= '0;
      seq_err_o        <= 1'b0;
      first_err_addr_o <= '0;
      first_err_port_o <= 2'b00;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      fail_o           <= 1'b0;
    end else begin
      exp_addr_q       <= exp_addr_d;
      seq_err_o        <= seq_err_d;
      first_err_addr_o <= first_err_addr_d;
      first_err_port_o <= first_err_port_d;
      done_o           <= done_d;
      pass_o           <= pass_d;
      fail_o           <= fail_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr (clr_c),
    .inc (mismatch_c),
    .q   (err_count_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr (clr_c),
    .inc (accept_c),
    .q   (sample_count)
  );

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Scoreboard bench for lutram_readback_checker: each pass's expected verdict
// is computed from the sample list and queued; a monitor pops it when done_o rises.
module tb_lutram_readback_checker;

  localparam int N       = 32;
  localparam int ERR_MAX = 63;

  logic       clk = 1'b0;
  logic       rst_i, start_i, valid_i, last_i;
  logic [4:0] addr_i;
  logic [0:0] spo_i, dpo_i;
  logic       done_o, pass_o, fail_o, seq_err_o;
  logic [5:0] err_count_o;
  logic [4:0] first_err_addr_o;
  logic [1:0] first_err_port_o;

  lutram_readback_checker #(.A_WIDTH(5), .D_WIDTH(1)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .valid_i          (valid_i),
    .last_i           (last_i),
    .addr_i           (addr_i),
    .spo_i            (spo_i),
    .dpo_i            (dpo_i),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .fail_o           (fail_o),
    .err_count_o      (err_count_o),
    .first_err_addr_o (first_err_addr_o),
    .first_err_port_o (first_err_port_o),
    .seq_err_o        (seq_err_o)
  );

  typedef struct {
    int errs;
    int faddr;
    int fport;
    bit seq;
    bit pass;
    int done_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] p_addr[$];
  logic       p_spo[$];
  logic       p_dpo[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic       done_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one expected verdict per rising done_o.
  always @(negedge clk) begin
    if (rst_i) begin
      done_prev <= 1'b0;
    end else begin
      exp_t e;
      if (done_o && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_latency",   cyc, e.done_cyc);
          check("pass",           pass_o, e.pass);
          check("fail",           fail_o, !e.pass);
          check("err_count",      err_count_o, e.errs);
          check("first_err_addr", first_err_addr_o, e.faddr);
          check("first_err_port", first_err_port_o, e.fport);
          check("seq_err",        seq_err_o, e.seq);
        end
      end
      done_prev <= done_o;
    end
  end

  task automatic make_clean(input int n);
    logic [4:0] a;
    p_addr.delete(); p_spo.delete(); p_dpo.delete();
    for (int i = 0; i < n; i++) begin
      a = 5'(i % N);
      p_addr.push_back(a);
      p_spo.push_back(a[0]);
      p_dpo.push_back(a[0]);
    end
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; last_i = 1'b0; start_i = 1'b0;
    addr_i = 5'($urandom_range(31)); spo_i = 1'($urandom_range(1)); dpo_i = 1'($urandom_range(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"},  done_o, 0);
    check({tag, "_pass"},  pass_o, 0);
    check({tag, "_fail"},  fail_o, 0);
    check({tag, "_errs"},  err_count_o, 0);
    check({tag, "_faddr"}, first_err_addr_o, 0);
    check({tag, "_fport"}, first_err_port_o, 0);
    check({tag, "_seq"},   seq_err_o, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 idle_inputs(); start_i = 1'b1;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    check("done_clear_after_start", done_o, 0);
    check("errs_clear_after_start", err_count_o, 0);
  endtask

  // Drive samples without last_i and without queueing a verdict.
  task automatic drive_raw();
    for (int i = 0; i < p_addr.size(); i++) begin
      @(posedge clk); #1 start_i = 1'b0; valid_i = 1'b1; last_i = 1'b0;
      addr_i = p_addr[i]; spo_i = p_spo[i]; dpo_i = p_dpo[i];
    end
  endtask

  task automatic send_pass(input bit do_start, input bit gaps);
    exp_t e;
    int   n;
    n = p_addr.size();
    if (do_start) pulse_start();
    // Reference verdict from the pattern rules.
    e.errs = 0; e.faddr = 0; e.fport = 0; e.seq = (n != N);
    for (int i = 0; i < n; i++) begin
      logic ex;
      int   m;
      ex = p_addr[i][0];
      m  = 0;
      if (p_spo[i] != ex) m += 1;
      if (p_dpo[i] != ex) m += 2;
      if (m != 0) begin
        if (e.errs == 0) begin e.faddr = int'(p_addr[i]); e.fport = m; end
        if (e.errs < ERR_MAX) e.errs++;
      end
      if (int'(p_addr[i]) != i % N) e.seq = 1'b1;
    end
    e.pass = (e.errs == 0) && !e.seq;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1 idle_inputs(); end
      @(posedge clk); #1 start_i = 1'b0; valid_i = 1'b1;
      addr_i = p_addr[i]; spo_i = p_spo[i]; dpo_i = p_dpo[i]; last_i = (i == n - 1);
      if (i == n - 1) begin e.done_cyc = cyc + 1; sb.push_back(e); end
    end
    @(posedge clk); #1 idle_inputs();
    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Samples in IDLE are ignored.
    make_clean(4);
    for (int i = 0; i < 4; i++) p_spo[i] = ~p_spo[i];
    drive_raw();
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    check("idle_ignored_errs", err_count_o, 0);
    check("idle_ignored_done", done_o, 0);

    make_clean(32); send_pass(1, 0);                                   // clean
    make_clean(32); p_spo[7] = ~p_spo[7]; send_pass(1, 0);             // SPO flip
    make_clean(32); p_dpo[3] = ~p_dpo[3]; p_dpo[20] = ~p_dpo[20];
    send_pass(1, 0);                                                   // DPO flips
    make_clean(16); send_pass(1, 0);                                   // early last
    make_clean(32); p_addr[9] = 5'd10; p_spo[9] = 1'b0; p_dpo[9] = 1'b0;
    send_pass(1, 0);                                                   // skipped addr
    make_clean(70);
    for (int i = 0; i < 70; i++) p_spo[i] = ~p_spo[i];
    send_pass(1, 1);                                                   // saturation

    // Restart in CHECK: same-cycle sample (with last_i) is discarded.
    pulse_start();
    make_clean(10);
    for (int i = 0; i < 10; i++) p_dpo[i] = ~p_dpo[i];
    drive_raw();
    @(posedge clk); #1 start_i = 1'b1; valid_i = 1'b1; last_i = 1'b1; addr_i = 5'd3; spo_i = 1'b0;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    check("restart_errs", err_count_o, 0);
    check("restart_done", done_o, 0);
    make_clean(32); send_pass(0, 1);

    // Reset at sample 12, then a new clean pass.
    pulse_start();
    make_clean(12);
    for (int i = 0; i < 12; i++) p_spo[i] = ~p_spo[i];
    p_addr[5] = 5'd30;
    drive_raw();
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0; idle_inputs();
    @(negedge clk);
    check_all_zero("midreset");
    make_clean(32); send_pass(1, 1);

    // Randomised passes.
    repeat (20) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : N;
      make_clean(n);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(15) == 0) p_spo[i] = ~p_spo[i];
        if ($urandom_range(15) == 0) p_dpo[i] = ~p_dpo[i];
        if ($urandom_range(31) == 0) p_addr[i] = 5'($urandom_range(31));
      end
      send_pass(1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
